// File: rtl/bus_pkg.sv
// Shared definitions for the host-side device bus port: bus width,
// idle/release byte values and the port state encoding.
package bus_pkg;

  localparam int BUS_W = 8;

  localparam logic [BUS_W-1:0] BUS_IDLE_BYTE = 8'h00;
  localparam logic [BUS_W-1:0] BUS_RELEASE   = 8'bzzzz_zzzz;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    TURN_RX,
    RECV,
    TURN_TX
  } busState_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is always visible
// on rdata_o; pushes while full and pops while empty are ignored.
module byte_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  assign w_push  = push_i && !w_full;
  assign w_pop   = pop_i && !w_empty;

  assign rdata_o = r_mem[r_rdPtr];
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign count_o = r_count;

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping; reset flushes the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_host_port.sv
// Host side of the half-duplex device bus. Buffers outgoing bursts, drives
// them one byte per clock, releases the bus for a programmed number of reply
// bytes, then takes the bus back after a turnaround gap.
module bus_host_port
  import bus_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [BUS_W-1:0] tx_data_i,
  input  logic             tx_last_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  input  logic [7:0]       rx_len_i,
  output logic [BUS_W-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             busy_o,
  output logic             underrun_o,
  output logic             tx_oe,
  inout  wire  [BUS_W-1:0] data_io
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ALMOST_FULL = CW'(DEPTH - 1);
  localparam logic [3:0]    TURN_LOAD   = 4'(TURN_CYCLES);
  localparam logic [3:0]    TURN_TAIL   = 4'(TURN_CYCLES - 1);

  busState_t        r_state;
  busState_t        w_stateNext;
  logic [CW-1:0]    r_frames;
  logic [3:0]       r_turnCnt;
  logic [3:0]       w_turnCntNext;
  logic [7:0]       r_rxCnt;
  logic [7:0]       w_rxCntNext;
  logic [BUS_W-1:0] r_txQ;
  logic [BUS_W-1:0] r_rxData;
  logic             r_txOe;
  logic             r_rxValid;
  logic             r_busy;
  logic             r_underrun;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_pushLast;
  logic             w_popLast;
  logic             w_startBurst;
  logic [8:0]       w_head;
  logic [CW-1:0]    w_count;

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (9)
  ) u_txFifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .wdata_i ({tx_last_i, tx_data_i}),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign tx_ready_o = !w_full;
  assign w_push     = tx_valid_i && !w_full;
  assign w_pop      = (r_state == DRIVE) && !w_empty;
  assign w_pushLast = w_push && tx_last_i;
  assign w_popLast  = w_pop && w_head[8];

  // A burst starts in the same cycle its last byte (or the filling byte)
  // is accepted, so DRIVE begins on the very next clock.
  assign w_startBurst = (r_frames != '0) || w_pushLast || w_full ||
                        (w_push && (w_count == ALMOST_FULL));

  assign rx_data_o  = r_rxData;
  assign rx_valid_o = r_rxValid;
  assign busy_o     = r_busy;
  assign underrun_o = r_underrun;
  assign tx_oe      = r_txOe;

  assign data_io = r_txOe ? BUS_RELEASE : r_txQ;

  // Next-state, turnaround counter and reply counter decisions.
  always_comb begin
    w_stateNext   = r_state;
    w_turnCntNext = r_turnCnt;
    w_rxCntNext   = r_rxCnt;
    case (r_state)
      IDLE: begin
        if (w_startBurst) begin
          w_stateNext = DRIVE;
        end
      end
      DRIVE: begin
        if (w_popLast) begin
          w_stateNext   = TURN_RX;
          w_turnCntNext = TURN_LOAD;
          w_rxCntNext   = rx_len_i;
        end
      end
      TURN_RX: begin
        if (r_turnCnt == 4'd0) begin
          if (r_rxCnt != 8'd0) begin
            w_stateNext = RECV;
          end else begin
            w_stateNext   = TURN_TX;
            w_turnCntNext = TURN_TAIL;
          end
        end else begin
          w_turnCntNext = r_turnCnt - 4'd1;
        end
      end
      RECV: begin
        w_rxCntNext = r_rxCnt - 8'd1;
        if (r_rxCnt == 8'd1) begin
          w_stateNext   = TURN_TX;
          w_turnCntNext = TURN_TAIL;
        end
      end
      TURN_TX: begin
        if (r_turnCnt == 4'd0) begin
          w_stateNext = IDLE;
        end else begin
          w_turnCntNext = r_turnCnt - 4'd1;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State register together with the turnaround and reply counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_turnCnt <= 4'd0;
      r_rxCnt   <= 8'd0;
    end else begin
      r_state   <= w_stateNext;
      r_turnCnt <= w_turnCntNext;
      r_rxCnt   <= w_rxCntNext;
    end
  end

  // Count of complete bursts waiting in the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_frames <= '0;
    end else begin
      case ({w_pushLast, w_popLast})
        2'b10:   r_frames <= r_frames + CW'(1);
        2'b01:   r_frames <= r_frames - CW'(1);
        default: r_frames <= r_frames;
      endcase
    end
  end

  // Registered outputs; tx_oe rises one cycle after the last byte leaves so
  // that byte gets a full cycle on the bus, and falls when IDLE is entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_txQ      <= BUS_IDLE_BYTE;
      r_txOe     <= 1'b0;
      r_rxData   <= BUS_IDLE_BYTE;
      r_rxValid  <= 1'b0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_busy     <= (w_stateNext != IDLE);
      r_underrun <= (r_state == DRIVE) && w_empty;
      r_rxValid  <= (r_state == RECV);
      r_txOe     <= (r_state inside {TURN_RX, RECV, TURN_TX}) && (w_stateNext != IDLE);
      if (r_state == RECV) begin
        r_rxData <= data_io;
      end
      if (r_state == DRIVE) begin
        if (w_pop) begin
          r_txQ <= w_head[7:0];
        end
      end else begin
        r_txQ <= BUS_IDLE_BYTE;
      end
    end
  end

endmodule

// File: tb/tb_bus_host_port.sv
// Directed bench for bus_host_port: one instance with a single-cycle
// turnaround and a second with a three-cycle turnaround, both acting as the
// Device on their own bus.
module tb_bus_host_port;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] txData = 8'h00;
  logic       txLast = 1'b0;
  logic       txValid = 1'b0;
  logic       txReady;
  logic [7:0] rxLen = 8'h00;
  logic [7:0] rxData;
  logic       rxValid;
  logic       busy;
  logic       underrun;
  logic       txOe;
  logic [7:0] devData = 8'hEE;
  wire  [7:0] dataIo;

  logic [7:0] txData3 = 8'h00;
  logic       txLast3 = 1'b0;
  logic       txValid3 = 1'b0;
  logic       txReady3;
  logic [7:0] rxLen3 = 8'h00;
  logic [7:0] rxData3;
  logic       rxValid3;
  logic       busy3;
  logic       underrun3;
  logic       txOe3;
  logic [7:0] devData3 = 8'hEE;
  wire  [7:0] dataIo3;

  int nCompared = 0;
  int nMismatched = 0;

  logic [7:0] expByte;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  assign dataIo  = txOe  ? devData  : 8'hzz;
  assign dataIo3 = txOe3 ? devData3 : 8'hzz;

  bus_host_port #(
    .DEPTH       (8),
    .TURN_CYCLES (1)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_data_i  (txData),
    .tx_last_i  (txLast),
    .tx_valid_i (txValid),
    .tx_ready_o (txReady),
    .rx_len_i   (rxLen),
    .rx_data_o  (rxData),
    .rx_valid_o (rxValid),
    .busy_o     (busy),
    .underrun_o (underrun),
    .tx_oe      (txOe),
    .data_io    (dataIo)
  );

  bus_host_port #(
    .DEPTH       (8),
    .TURN_CYCLES (3)
  ) dut3 (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_data_i  (txData3),
    .tx_last_i  (txLast3),
    .tx_valid_i (txValid3),
    .tx_ready_o (txReady3),
    .rx_len_i   (rxLen3),
    .rx_data_o  (rxData3),
    .rx_valid_o (rxValid3),
    .busy_o     (busy3),
    .underrun_o (underrun3),
    .tx_oe      (txOe3),
    .data_io    (dataIo3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int port, input logic valid, input logic [7:0] data,
                               input logic last);
    if (port == 3) begin
      txValid3 = valid;
      txData3  = data;
      txLast3  = last;
    end else begin
      txValid = valid;
      txData  = data;
      txLast  = last;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset held for ten cycles while a last-marked byte is offered.
    for (int i = 0; i < 10; i++) begin
      step();
      rst = 1'b1;
      applyStimulus(1, 1'b1, 8'h99, 1'b1);
    end
    checkOutput("rst_txOe", {7'd0, txOe}, 8'h00);
    checkOutput("rst_dataIo", dataIo, 8'h00);
    checkOutput("rst_rxValid", {7'd0, rxValid}, 8'h00);
    checkOutput("rst_rxData", rxData, 8'h00);
    checkOutput("rst_busy", {7'd0, busy}, 8'h00);
    checkOutput("rst_underrun", {7'd0, underrun}, 8'h00);
    step();
    rst = 1'b0;
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    step();
    checkOutput("rst_txReady", {7'd0, txReady}, 8'h01);
    checkOutput("rst_busyAfter", {7'd0, busy}, 8'h00);
    step();
    step();
    checkOutput("rst_flushBusy", {7'd0, busy}, 8'h00);
    checkOutput("rst_flushBus", dataIo, 8'h00);

    // Three-byte burst with a two-byte reply.
    rxLen = 8'd2;
    applyStimulus(1, 1'b1, 8'hFF, 1'b0);
    step();
    applyStimulus(1, 1'b1, 8'h0F, 1'b0);
    step();
    applyStimulus(1, 1'b1, 8'h01, 1'b1);
    step();
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    checkOutput("b_busyDrive", {7'd0, busy}, 8'h01);
    checkOutput("b_idleByte", dataIo, 8'h00);
    step();
    checkOutput("b_byte0", dataIo, 8'hFF);
    checkOutput("b_oe0", {7'd0, txOe}, 8'h00);
    step();
    checkOutput("b_byte1", dataIo, 8'h0F);
    step();
    checkOutput("b_byte2", dataIo, 8'h01);
    checkOutput("b_oeLast", {7'd0, txOe}, 8'h00);
    step();
    checkOutput("b_oeTurn", {7'd0, txOe}, 8'h01);
    checkOutput("b_noEarlyRx", {7'd0, rxValid}, 8'h00);
    step();
    devData = 8'hA5;
    checkOutput("b_oeRecv0", {7'd0, txOe}, 8'h01);
    checkOutput("b_noRxYet", {7'd0, rxValid}, 8'h00);
    step();
    devData = 8'h5A;
    checkOutput("b_rxValid0", {7'd0, rxValid}, 8'h01);
    checkOutput("b_rxData0", rxData, 8'hA5);
    step();
    devData = 8'hEE;
    checkOutput("b_rxValid1", {7'd0, rxValid}, 8'h01);
    checkOutput("b_rxData1", rxData, 8'h5A);
    checkOutput("b_oeTail", {7'd0, txOe}, 8'h01);
    step();
    checkOutput("b_oeBack", {7'd0, txOe}, 8'h00);
    checkOutput("b_busBack", dataIo, 8'h00);
    checkOutput("b_rxDone", {7'd0, rxValid}, 8'h00);
    checkOutput("b_idle", {7'd0, busy}, 8'h00);

    // Walking-one burst that fills the FIFO exactly; no reply expected.
    rxLen = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        step();
      end
      expByte = 8'h01 << i;
      applyStimulus(1, 1'b1, expByte, i == 7);
    end
    step();
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    checkOutput("c_fullReady", {7'd0, txReady}, 8'h00);
    checkOutput("c_busy", {7'd0, busy}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      step();
      expByte = 8'h01 << i;
      checkOutput($sformatf("c_walk%0d", i), dataIo, expByte);
    end
    step();
    checkOutput("c_oe1", {7'd0, txOe}, 8'h01);
    checkOutput("c_noRx1", {7'd0, rxValid}, 8'h00);
    step();
    checkOutput("c_oe2", {7'd0, txOe}, 8'h01);
    checkOutput("c_noRx2", {7'd0, rxValid}, 8'h00);
    step();
    checkOutput("c_oeBack", {7'd0, txOe}, 8'h00);
    checkOutput("c_noRx3", {7'd0, rxValid}, 8'h00);
    checkOutput("c_idle", {7'd0, busy}, 8'h00);

    // Full FIFO without a last marker, then a late byte leaves a gap.
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        step();
      end
      applyStimulus(1, 1'b1, 8'h30 + 8'(i), 1'b0);
    end
    step();
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    checkOutput("d_busyFull", {7'd0, busy}, 8'h01);
    for (int i = 0; i < 7; i++) begin
      step();
      checkOutput($sformatf("d_fill%0d", i), dataIo, 8'h30 + 8'(i));
    end
    applyStimulus(1, 1'b1, 8'h11, 1'b0);
    step();
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    checkOutput("d_fill7", dataIo, 8'h37);
    checkOutput("d_noUnder0", {7'd0, underrun}, 8'h00);
    step();
    applyStimulus(1, 1'b1, 8'h22, 1'b1);
    checkOutput("d_byte11", dataIo, 8'h11);
    checkOutput("d_noUnder1", {7'd0, underrun}, 8'h00);
    step();
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    checkOutput("d_holdBus", dataIo, 8'h11);
    checkOutput("d_underrun", {7'd0, underrun}, 8'h01);
    step();
    checkOutput("d_byte22", dataIo, 8'h22);
    checkOutput("d_underClear", {7'd0, underrun}, 8'h00);
    step();
    step();
    step();
    checkOutput("d_idle", {7'd0, busy}, 8'h00);

    // Reset during a reply with another complete burst still queued.
    rxLen = 8'd3;
    applyStimulus(1, 1'b1, 8'h5C, 1'b1);
    step();
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    step();
    checkOutput("e_byte", dataIo, 8'h5C);
    step();
    applyStimulus(1, 1'b1, 8'h77, 1'b1);
    devData = 8'hC3;
    step();
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    step();
    checkOutput("e_rxValid", {7'd0, rxValid}, 8'h01);
    checkOutput("e_rxData", rxData, 8'hC3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    devData = 8'hEE;
    checkOutput("e_busy", {7'd0, busy}, 8'h00);
    checkOutput("e_oe", {7'd0, txOe}, 8'h00);
    checkOutput("e_bus", dataIo, 8'h00);
    checkOutput("e_rxValidOff", {7'd0, rxValid}, 8'h00);
    checkOutput("e_rxDataClr", rxData, 8'h00);
    step();
    checkOutput("e_discard1", {7'd0, busy}, 8'h00);
    step();
    checkOutput("e_discard2", {7'd0, busy}, 8'h00);
    checkOutput("e_busIdle", dataIo, 8'h00);
    rxLen = 8'd0;
    applyStimulus(1, 1'b1, 8'h66, 1'b1);
    step();
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    step();
    checkOutput("e_freshByte", dataIo, 8'h66);
    step();
    step();
    step();
    checkOutput("e_idle", {7'd0, busy}, 8'h00);

    // Three-cycle turnaround on both sides of a one-byte reply.
    rxLen3 = 8'd1;
    checkOutput("f_ready", {7'd0, txReady3}, 8'h01);
    applyStimulus(3, 1'b1, 8'hAA, 1'b1);
    step();
    applyStimulus(3, 1'b0, 8'h00, 1'b0);
    step();
    checkOutput("f_byte", dataIo3, 8'hAA);
    checkOutput("f_oeLast", {7'd0, txOe3}, 8'h00);
    checkOutput("f_noUnder", {7'd0, underrun3}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("f_preOe%0d", i), {7'd0, txOe3}, 8'h01);
      checkOutput($sformatf("f_preRx%0d", i), {7'd0, rxValid3}, 8'h00);
    end
    step();
    devData3 = 8'h3C;
    checkOutput("f_sampleOe", {7'd0, txOe3}, 8'h01);
    step();
    devData3 = 8'hEE;
    checkOutput("f_rxValid", {7'd0, rxValid3}, 8'h01);
    checkOutput("f_rxData", rxData3, 8'h3C);
    checkOutput("f_postOe0", {7'd0, txOe3}, 8'h01);
    step();
    checkOutput("f_postOe1", {7'd0, txOe3}, 8'h01);
    checkOutput("f_rxOnce", {7'd0, rxValid3}, 8'h00);
    step();
    checkOutput("f_postOe2", {7'd0, txOe3}, 8'h01);
    step();
    checkOutput("f_oeBack", {7'd0, txOe3}, 8'h00);
    checkOutput("f_busBack", dataIo3, 8'h00);
    checkOutput("f_idle", {7'd0, busy3}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/bus_host_port.md
# bus_host_port

Host-side half-duplex port for the shared 8-bit bidirectional device bus. It buffers outgoing bytes in a small FIFO and drives each burst onto `data_io` one byte per clock. It then releases the bus and raises `tx_oe` so the Device drives. It captures a programmed number of reply bytes and takes the bus back. It sits directly upstream of `Device` and replaces the hand-driven testbench bus master.

## Interface
- `DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `TURN_CYCLES`, 1: idle cycles at each bus turnaround; 1..15.
- `clk_i` in 1: single clock, all logic on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `tx_data_i` in 8: byte to send.
- `tx_last_i` in 1: marks final byte of a burst.
- `tx_valid_i` in 1: byte offered.
- `tx_ready_o` out 1: FIFO not full; a byte is accepted when `tx_valid_i && tx_ready_o`.
- `rx_len_i` in 8: reply byte count; latched when the last TX byte is popped.
- `rx_data_o` out 8: captured reply byte.
- `rx_valid_o` out 1: one-cycle strobe per reply byte; no backpressure.
- `busy_o` out 1: state ≠ IDLE.
- `underrun_o` out 1: strobe; FIFO empty mid-burst.
- `tx_oe` out 1: 0 = this block drives `data_io`; 1 = bus released to the Device.
- `data_io` inout 8: shared bus; driven with `tx_q` when `tx_oe`=0, else `8'bzzzz_zzzz`.

## Operation
- FIFO entries are 9 bits {last, data}.
- `frames` counts last-marked entries in the FIFO. It increments on push-with-last and decrements on pop-with-last; a simultaneous push-last and pop-last leaves it unchanged.
- States: IDLE, DRIVE, TURN_RX, RECV, TURN_TX.
- **IDLE**:
  - `tx_oe`=0 and `tx_q`=0x00, so the bus is driven low.
  - Go to DRIVE when `frames`>0 or the FIFO is full.
- **DRIVE**:
  - When the FIFO is non-empty, pop the head into `tx_q` each cycle.
  - When the FIFO is empty, `tx_q` holds its value and `underrun_o`=1 that cycle.
  - On popping a last-marked entry, latch `rx_len_i` into `rx_cnt` and go to TURN_RX.
- **TURN_RX**:
  - `tx_oe`=1 and the bus is released.
  - Wait `TURN_CYCLES`, then go to RECV if `rx_cnt`≠0, else go to TURN_TX.
- **RECV**:
  - Sample `data_io` into `rx_data_o` each cycle and pulse `rx_valid_o`.
  - Decrement `rx_cnt`; on reaching 0, go to TURN_TX.
- **TURN_TX**:
  - `tx_oe`=1 and `tx_q`=0x00.
  - Wait `TURN_CYCLES`, then go to IDLE with `tx_oe`=0.
- Pushes are accepted in every state, including mid-burst.
- Reset (also mid-burst or mid-receive):
  - FIFO flushed, `frames`=0, state IDLE.
  - `tx_oe`=0, `tx_q`=0x00, so `data_io` = 0x00.
  - `rx_data_o`=0x00; `rx_valid_o`, `busy_o` and `underrun_o` all 0.
  - `tx_ready_o`=1 the cycle after reset deasserts.
- Empty/full rules:
  - A push while full is ignored, since `tx_ready_o`=0 then.
  - A simultaneous push and pop while full is not allowed: ready is derived from the registered count.

## Timing
- All outputs are registered.
- Push to bus: a burst's last byte pushed at cycle N (FIFO otherwise holding the burst) gives DRIVE at N+1. The first byte appears on `data_io` at N+2, and bytes follow back-to-back.
- Last byte on the bus at cycle M ⇒ `tx_oe`=1 from M+1 for `TURN_CYCLES` cycles.
- With `TURN_CYCLES`=1, the first RX sample is taken at M+2. `rx_valid_o`/`rx_data_o` are visible at M+3, then one per cycle.
- After the final RX sample, `tx_oe` stays 1 for `TURN_CYCLES`, then drops to 0 with `data_io`=0x00.
- `tx_ready_o` reflects the count after the current edge; there is no combinational path from `tx_valid_i`.

## Structure
- Package `bus_pkg`:
  - state enum;
  - `BUS_W`=8;
  - `BUS_IDLE_BYTE`=8'h00;
  - `BUS_RELEASE`=8'bzzzz_zzzz.
- Sub-module `byte_fifo`: synchronous FIFO with parameters DEPTH and WIDTH=9, and ports push/pop/full/empty/count.
- The top level holds the FSM, `frames`, turnaround counter, `rx_cnt` and the tri-state assign.

## Test plan
- Reset held 10 cycles with bytes pushed during reset → `tx_oe`=0, `data_io`=0x00, FIFO empty, `rx_valid_o`=0.
- Push 0xFF, 0x0F, 0x01(last) with `rx_len_i`=2; bench drives 0xA5, 0x5A after release → bus shows FF, 0F, 01 on consecutive cycles. Then `tx_oe`=1; `rx_data_o` shows A5 then 5A with 2 strobes; `tx_oe`=0 after 1 turnaround cycle.
- Walking-one burst 0x01…0x80 (8 bytes, last on 0x80) with DEPTH=8 and `rx_len_i`=0 → full FIFO starts DRIVE, all 8 bytes appear in order, no RECV, `tx_oe` high for 2 cycles total.
- Push 0x11, then 0x22 two cycles later, with the FIFO full (no last) → `underrun_o` pulses while the bus holds 0x11, then 0x22 is driven.
- Assert `rst_i` mid-RECV → next cycle state IDLE, `tx_oe`=0, `data_io`=0x00, pending FIFO bytes discarded.
- `TURN_CYCLES`=3 with `rx_len_i`=1 → exactly 3 released idle cycles before the sample and 3 after it.
